// File: rtl/fetch_stage.sv
// Instruction fetch stage: 12-bit word-addressed PC, synchronous instruction
// memory interface, and the F/EX pipeline register with redirect flush and stall.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_F,
  input  logic [2:0]  pc_src,
  input  logic [12:0] branch_offset_EX,
  input  logic [20:0] jal_offset_EX,
  input  logic [31:0] jalr_target_EX,
  output logic [11:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [11:0] pc_F,
  output logic [31:0] instruction_EX,
  output logic [11:0] pc_EX,
  output logic [31:0] pc_plus4_EX,
  output logic        valid_EX
);

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [2:0]  SRC_BRANCH = 3'b001;
  localparam logic [2:0]  SRC_JAL    = 3'b010;
  localparam logic [2:0]  SRC_JALR   = 3'b011;

  // Sign-extend a B-type byte offset to a 12-bit word offset (bits [1:0] dropped).
  function automatic logic [11:0] branch_word_offset(input logic [12:0] byte_off);
    branch_word_offset = {byte_off[12], byte_off[12:2]};
  endfunction

  // J-type word offset; only the low 12 bits of the sign-extended value can
  // influence a modulo-4096 sum, and those are exactly byte_off[13:2].
  function automatic logic [11:0] jal_word_offset(input logic [20:0] byte_off);
    jal_word_offset = byte_off[13:2];
  endfunction

  logic [11:0] pc_f_r;
  logic [31:0] instr_ex_r;
  logic [11:0] pc_ex_r;
  logic        valid_ex_r;

  logic [11:0] pc_next_s;
  logic        redirect_s;
  logic [11:0] redirect_target_s;
  logic        unused_s;

  // Offset/target bits that cannot affect a 12-bit word address.
  assign unused_s = ^{branch_offset_EX[1:0], jal_offset_EX[20:14], jal_offset_EX[1:0],
                      jalr_target_EX[31:14], jalr_target_EX[1:0]};

  // Decode the redirect select and its word-address target; 1xx behaves as sequential.
  always_comb begin
    redirect_s        = 1'b0;
    redirect_target_s = 12'd0;
    case (pc_src)
      SRC_BRANCH: begin
        redirect_s        = 1'b1;
        redirect_target_s = pc_ex_r + branch_word_offset(branch_offset_EX);
      end
      SRC_JAL: begin
        redirect_s        = 1'b1;
        redirect_target_s = pc_ex_r + jal_word_offset(jal_offset_EX);
      end
      SRC_JALR: begin
        // Clearing bit 0 of the byte address never reaches the [13:2] slice.
        redirect_s        = 1'b1;
        redirect_target_s = jalr_target_EX[13:2];
      end
      default: begin
        redirect_s        = 1'b0;
        redirect_target_s = 12'd0;
      end
    endcase
  end

  // Next fetch address: reset, then redirect (beats stall), then stall hold, then +1.
  always_comb begin
    pc_next_s = pc_f_r + 12'd1;
    if (rst) begin
      pc_next_s = 12'd0;
    end else if (redirect_s) begin
      pc_next_s = redirect_target_s;
    end else if (stall_F) begin
      pc_next_s = pc_f_r;
    end else begin
      pc_next_s = pc_f_r + 12'd1;
    end
  end

  // Fetch PC follows the address presented to memory so rdata always matches pc_F.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_r <= 12'd0;
    end else begin
      pc_f_r <= pc_next_s;
    end
  end

  // F/EX register: flush on redirect, hold on stall, otherwise capture the fetched word.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ex_r <= NOP_INSTR;
      pc_ex_r    <= 12'd0;
      valid_ex_r <= 1'b0;
    end else if (redirect_s) begin
      instr_ex_r <= NOP_INSTR;
      pc_ex_r    <= pc_f_r;
      valid_ex_r <= 1'b0;
    end else if (!stall_F) begin
      instr_ex_r <= imem_rdata;
      pc_ex_r    <= pc_f_r;
      valid_ex_r <= 1'b1;
    end
  end

  assign imem_addr      = pc_next_s;
  assign pc_F           = pc_f_r;
  assign instruction_EX = instr_ex_r;
  assign pc_EX          = pc_ex_r;
  assign valid_EX       = valid_ex_r;
  // Link value: byte address of the EX instruction plus 4 (4095 -> 32'h4000).
  assign pc_plus4_EX    = {18'd0, pc_ex_r, 2'b00} + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a short
// hand-written reset/stall sequence, and a randomized run against a
// byte-address arithmetic reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_F;
  logic [2:0]  pc_src;
  logic [12:0] branch_offset_EX;
  logic [20:0] jal_offset_EX;
  logic [31:0] jalr_target_EX;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [11:0] pc_F;
  logic [31:0] instruction_EX;
  logic [11:0] pc_EX;
  logic [31:0] pc_plus4_EX;
  logic        valid_EX;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall_F          (stall_F),
    .pc_src           (pc_src),
    .branch_offset_EX (branch_offset_EX),
    .jal_offset_EX    (jal_offset_EX),
    .jalr_target_EX   (jalr_target_EX),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .pc_F             (pc_F),
    .instruction_EX   (instruction_EX),
    .pc_EX            (pc_EX),
    .pc_plus4_EX      (pc_plus4_EX),
    .valid_EX         (valid_EX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word n holds n + 0x100, synchronous read.
  logic [31:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h100 + 32'(i);
  end
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model state (current and predicted-next).
  int          m_pc_f, m_pc_ex, m_valid;
  logic [31:0] m_instr;
  int          n_pc_f, n_pc_ex, n_valid;
  logic [31:0] n_instr;

  // Byte address taken modulo 16384, returned as a word address.
  function automatic int wrap_word(input longint b);
    longint m;
    m = ((b % 64'sd16384) + 64'sd16384) % 64'sd16384;
    return int'(m / 64'sd4);
  endfunction

  task automatic model_predict(input logic r, input logic s, input logic [2:0] src,
                               input logic [12:0] bo, input logic [20:0] jo, input logic [31:0] jt);
    int     off;
    longint b;
    bit     redir;
    redir = !r && (src == 3'd1 || src == 3'd2 || src == 3'd3);
    if (r) n_pc_f = 0;
    else if (src == 3'd1) begin off = $signed(bo); n_pc_f = wrap_word(longint'(m_pc_ex) * 4 + off); end
    else if (src == 3'd2) begin off = $signed(jo); n_pc_f = wrap_word(longint'(m_pc_ex) * 4 + off); end
    else if (src == 3'd3) begin b = jt & 32'hFFFF_FFFE; n_pc_f = wrap_word(b); end
    else if (s) n_pc_f = m_pc_f;
    else n_pc_f = (m_pc_f + 1) % 4096;
    if (r) begin
      n_instr = NOP; n_pc_ex = 0; n_valid = 0;
    end else if (redir) begin
      n_instr = NOP; n_pc_ex = m_pc_f; n_valid = 0;
    end else if (s) begin
      n_instr = m_instr; n_pc_ex = m_pc_ex; n_valid = m_valid;
    end else begin
      n_instr = mem[m_pc_f]; n_pc_ex = m_pc_f; n_valid = 1;
    end
  endtask

  // Drive one cycle's inputs mid-cycle and let the model predict the edge.
  task automatic drive(input logic r, input logic s, input logic [2:0] src,
                       input logic [12:0] bo, input logic [20:0] jo, input logic [31:0] jt);
    @(negedge clk);
    rst = r; stall_F = s; pc_src = src;
    branch_offset_EX = bo; jal_offset_EX = jo; jalr_target_EX = jt;
    #1;
    model_predict(r, s, src, bo, jo, jt);
  endtask

  task automatic edge_commit();
    @(posedge clk);
    #1;
    m_pc_f = n_pc_f; m_pc_ex = n_pc_ex; m_valid = n_valid; m_instr = n_instr;
  endtask

  typedef struct packed {
    logic        r;
    logic        s;
    logic [2:0]  src;
    logic [12:0] bo;
    logic [20:0] jo;
    logic [31:0] jt;
    logic [11:0] e_addr;
    logic [11:0] e_pcf;
    logic [31:0] e_instr;
    logic [11:0] e_pcex;
    logic        e_valid;
    logic [31:0] e_p4;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] src,
                              input logic [12:0] bo, input logic [20:0] jo, input logic [31:0] jt,
                              input logic [11:0] ea, input logic [11:0] ep, input logic [31:0] ei,
                              input logic [11:0] ex, input logic ev, input logic [31:0] e4);
    vec_t v;
    v.r = r; v.s = s; v.src = src; v.bo = bo; v.jo = jo; v.jt = jt;
    v.e_addr = ea; v.e_pcf = ep; v.e_instr = ei; v.e_pcex = ex; v.e_valid = ev; v.e_p4 = e4;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin : main
    logic        r_v, s_v;
    logic [2:0]  src_v;
    rst = 1'b1; stall_F = 1'b0; pc_src = 3'd0;
    branch_offset_EX = 13'd0; jal_offset_EX = 21'd0; jalr_target_EX = 32'd0;
    m_pc_f = 0; m_pc_ex = 0; m_valid = 0; m_instr = NOP;

    // r, s, src, bo, jo, jt | addr, pc_F, instr, pc_EX, valid, pc_plus4
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'd0, 12'd0, NOP, 12'd0, 1'b0, 32'd4));
    vecs.push_back(mk(1'b1, 1'b1, 3'd2, 13'd0, 21'd16, 32'd0, 12'd0, 12'd0, NOP, 12'd0, 1'b0, 32'd4));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'(i + 1), 12'(i + 1),
                        32'h100 + 32'(i), 12'(i), 1'b1, 32'(4 * i + 4)));
    vecs.push_back(mk(1'b0, 1'b0, 3'd1, 13'h1FF8, 21'd0, 32'd0, 12'd3, 12'd3, NOP, 12'd6, 1'b0, 32'd28));
    for (int i = 3; i < 7; i++)
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'(i + 1), 12'(i + 1),
                        32'h100 + 32'(i), 12'(i), 1'b1, 32'(4 * i + 4)));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 1'b1, 3'd0, 13'd0, 21'd0, 32'd0, 12'd7, 12'd7, 32'h106, 12'd6, 1'b1, 32'd28));
    for (int i = 7; i < 11; i++)
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'(i + 1), 12'(i + 1),
                        32'h100 + 32'(i), 12'(i), 1'b1, 32'(4 * i + 4)));
    vecs.push_back(mk(1'b0, 1'b1, 3'd2, 13'd0, 21'd16, 32'd0, 12'd14, 12'd14, NOP, 12'd11, 1'b0, 32'd48));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'd15, 12'd15, 32'h10E, 12'd14, 1'b1, 32'd60));
    vecs.push_back(mk(1'b0, 1'b0, 3'd3, 13'd0, 21'd0, 32'h0000_4003, 12'd0, 12'd0, NOP, 12'd15, 1'b0, 32'd64));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'd1, 12'd1, 32'h100, 12'd0, 1'b1, 32'd4));
    vecs.push_back(mk(1'b0, 1'b0, 3'd4, 13'd5, 21'd9, 32'd0, 12'd2, 12'd2, 32'h101, 12'd1, 1'b1, 32'd8));
    vecs.push_back(mk(1'b0, 1'b1, 3'd5, 13'd5, 21'd9, 32'd0, 12'd2, 12'd2, 32'h101, 12'd1, 1'b1, 32'd8));
    vecs.push_back(mk(1'b0, 1'b0, 3'd3, 13'd0, 21'd0, 32'h0000_3FFE, 12'hFFF, 12'hFFF, NOP, 12'd2, 1'b0, 32'd12));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'd0, 12'd0, 32'h10FF, 12'hFFF, 1'b1, 32'h4000));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'd1, 12'd1, 32'h100, 12'd0, 1'b1, 32'd4));
    vecs.push_back(mk(1'b0, 1'b0, 3'd3, 13'd0, 21'd0, 32'h0000_0050, 12'd20, 12'd20, NOP, 12'd1, 1'b0, 32'd8));
    vecs.push_back(mk(1'b0, 1'b1, 3'd0, 13'd0, 21'd0, 32'd0, 12'd20, 12'd20, NOP, 12'd1, 1'b0, 32'd8));
    vecs.push_back(mk(1'b1, 1'b1, 3'd0, 13'd0, 21'd0, 32'd0, 12'd0, 12'd0, NOP, 12'd0, 1'b0, 32'd4));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'd1, 12'd1, 32'h100, 12'd0, 1'b1, 32'd4));
    vecs.push_back(mk(1'b0, 1'b0, 3'd1, 13'd7, 21'd0, 32'd0, 12'd1, 12'd1, NOP, 12'd1, 1'b0, 32'd8));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'd2, 12'd2, 32'h101, 12'd1, 1'b1, 32'd8));
    vecs.push_back(mk(1'b0, 1'b0, 3'd2, 13'd0, 21'h1F_FFF8, 32'd0, 12'hFFF, 12'hFFF, NOP, 12'd2, 1'b0, 32'd12));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0, 12'd0, 12'd0, 32'h10FF, 12'hFFF, 1'b1, 32'h4000));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].src, vecs[i].bo, vecs[i].jo, vecs[i].jt);
      check($sformatf("vec%0d_imem_addr", i), {20'd0, imem_addr}, {20'd0, vecs[i].e_addr});
      edge_commit();
      check($sformatf("vec%0d_pc_F", i), {20'd0, pc_F}, {20'd0, vecs[i].e_pcf});
      check($sformatf("vec%0d_instr", i), instruction_EX, vecs[i].e_instr);
      check($sformatf("vec%0d_pc_EX", i), {20'd0, pc_EX}, {20'd0, vecs[i].e_pcex});
      check($sformatf("vec%0d_valid", i), {31'd0, valid_EX}, {31'd0, vecs[i].e_valid});
      check($sformatf("vec%0d_pc_plus4", i), pc_plus4_EX, vecs[i].e_p4);
    end

    // Hand-written: stall on the very first post-reset cycle, then resume.
    drive(1'b1, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0);
    edge_commit();
    drive(1'b0, 1'b1, 3'd0, 13'd0, 21'd0, 32'd0);
    check("seq_stall0_imem_addr", {20'd0, imem_addr}, 32'd0);
    edge_commit();
    check("seq_stall0_valid", {31'd0, valid_EX}, 32'd0);
    check("seq_stall0_instr", instruction_EX, NOP);
    check("seq_stall0_pc_F", {20'd0, pc_F}, 32'd0);
    drive(1'b0, 1'b0, 3'd0, 13'd0, 21'd0, 32'd0);
    check("seq_resume_imem_addr", {20'd0, imem_addr}, 32'd1);
    edge_commit();
    check("seq_resume_valid", {31'd0, valid_EX}, 32'd1);
    check("seq_resume_instr", instruction_EX, 32'h100);
    check("seq_resume_pc_EX", {20'd0, pc_EX}, 32'd0);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      r_v   = ($urandom_range(0, 99) < 2);
      s_v   = ($urandom_range(0, 99) < 25);
      src_v = ($urandom_range(0, 99) < 70) ? 3'd0 : 3'($urandom_range(1, 7));
      drive(r_v, s_v, src_v, 13'($urandom), 21'($urandom), $urandom);
      check("rnd_imem_addr", {20'd0, imem_addr}, 32'(n_pc_f));
      edge_commit();
      check("rnd_pc_F", {20'd0, pc_F}, 32'(m_pc_f));
      check("rnd_instr", instruction_EX, m_instr);
      check("rnd_pc_EX", {20'd0, pc_EX}, 32'(m_pc_ex));
      check("rnd_valid", {31'd0, valid_EX}, 32'(m_valid));
      check("rnd_pc_plus4", pc_plus4_EX, 32'(m_pc_ex * 4 + 4));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port stall_F  input  1  holds the fetch PC and the F/EX register when high.
REQ-004 SHALL have port pc_src  input  3  redirect select: 000 sequential, 001 branch taken, 010 jal, 011 jalr, 1xx reserved (treated as 000).
REQ-005 SHALL have port branch_offset_EX  input  13  signed B-type byte offset of the EX instruction.
REQ-006 SHALL have port jal_offset_EX  input  21  signed J-type byte offset of the EX instruction.
REQ-007 SHALL have port jalr_target_EX  input  32  byte address rs1+immI of the EX instruction.
REQ-008 SHALL have port imem_addr  output  12  word address to instruction memory (synchronous read, 1-cycle latency).
REQ-009 SHALL have port imem_rdata  input  32  word at the address presented on the previous edge.
REQ-010 SHALL have port pc_F  output  12  word address of the instruction currently returned on imem_rdata.
REQ-011 SHALL have port instruction_EX  output  32  instruction presented to the decode/control logic.
REQ-012 SHALL have port pc_EX  output  12  word address of instruction_EX.
REQ-013 SHALL have port pc_plus4_EX  output  32  byte address {18'b0, pc_EX, 2'b00} + 4, the jal/jalr link value.
REQ-014 SHALL have port valid_EX  output  1  instruction_EX is a real, unsquashed instruction.

Function
REQ-015 SHALL hold a 12-bit word-addressed PC register pc_F; all PC arithmetic is modulo 4096 (4095+1 wraps to 0).
REQ-016 SHALL compute pc_next combinationally with priority: rst -> 0; pc_src=001 -> pc_EX + branch_offset_EX[12:2] (sign-extended); 010 -> pc_EX + jal_offset_EX[20:2] (sign-extended); 011 -> jalr_target_EX[13:2], with bit 0 cleared before slicing; else stall_F -> pc_F; else pc_F + 1.
REQ-017 SHALL drive imem_addr = pc_next and register pc_F <= pc_next every cycle, so imem_rdata always corresponds to pc_F.
REQ-018 SHALL give a redirect (pc_src 001/010/011) priority over stall_F when both are asserted in the same cycle.
REQ-019 SHALL update the F/EX register on each edge when not redirecting and not stalled: instruction_EX <= imem_rdata, pc_EX <= pc_F, valid_EX <= 1.
REQ-020 SHALL, on a redirect cycle, flush the F/EX register: instruction_EX <= 32'h00000013 (addi x0,x0,0), valid_EX <= 0, and pc_EX <= pc_F.
REQ-021 SHALL, on a stall cycle without redirect, hold instruction_EX, pc_EX, valid_EX and pc_F unchanged.
REQ-022 SHALL give a taken branch or jump exactly one squashed slot: the target instruction appears in EX two edges after the redirect cycle, with valid_EX=1.
REQ-023 SHALL ignore low offset bits (branch_offset_EX[1:0], jal_offset_EX[1:0], jalr_target_EX[1]) and SHALL NOT raise misalignment traps.
REQ-024 SHALL derive pc_plus4_EX combinationally from pc_EX; 4095 yields 32'h00004000.

Reset
REQ-025 SHALL, while rst is high at an edge, set pc_F=0, instruction_EX=32'h00000013, pc_EX=0, valid_EX=0, and drive imem_addr=0 regardless of stall_F and pc_src.
REQ-026 SHALL, on the first edge after rst deasserts, load instruction_EX with the word at address 0 and set valid_EX=1, unless that cycle stalls or redirects.
REQ-027 SHALL abandon a redirect or stall in progress when rst asserts mid-operation, with no residual state.

Verification
REQ-028 SHALL cover sequential fetch: imem[n]=n+0x100, no stall -> instruction_EX sequence 0x100,0x101,0x102 with pc_EX 0,1,2 and valid_EX=1 from the first post-reset edge.
REQ-029 SHALL cover a taken branch: pc_EX=5, branch_offset_EX=-8, pc_src=001 -> next cycle valid_EX=0 and instruction_EX=0x00000013, pc_F=3; the cycle after, pc_EX=3 and valid_EX=1.
REQ-030 SHALL cover a stall: stall_F high for 3 cycles at pc_F=7 -> pc_F, imem_addr and instruction_EX constant; on release, fetch resumes at 8.
REQ-031 SHALL cover simultaneous stall_F=1 and pc_src=010 with pc_EX=10, jal_offset_EX=+16 -> pc_F=14 and a flush, with the stall ignored.
REQ-032 SHALL cover jalr wrap-around: jalr_target_EX=32'h00004003 -> pc_F=0; and pc_F=4095 sequential -> pc_F=0, pc_plus4_EX for pc_EX=4095 equal to 32'h00004000.
REQ-033 SHALL cover reset mid-stall: rst asserted during stall_F=1 at pc_F=20 -> pc_F=0, valid_EX=0, instruction_EX=0x00000013 after one edge.
